// File: rtl/tl_pkg.sv
// Shared TileLink D-channel definitions: opcodes, default geometry, beat record and beat-count helper.
package tl_pkg;

  localparam int TL_BEAT_BYTES = 8;
  localparam int TL_LINE_BYTES = 64;
  localparam int TL_SOURCE_W   = 6;

  localparam logic [2:0] TL_BEAT_LOG2 = 3'($clog2(TL_BEAT_BYTES));

  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
  localparam logic [2:0] D_GRANT           = 3'd4;
  localparam logic [2:0] D_GRANT_DATA      = 3'd5;
  localparam logic [2:0] D_RELEASE_ACK     = 3'd6;

  typedef struct packed {
    logic [2:0]             opcode;
    logic [1:0]             param;
    logic [2:0]             size;
    logic [TL_SOURCE_W-1:0] source;
    logic                   sink;
    logic                   denied;
    logic [63:0]            data;
    logic                   corrupt;
  } d_beat_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DONE
  } fill_state_e;

  function automatic logic is_data(input logic [2:0] opcode);
    return (opcode == D_ACCESS_ACK_DATA) || (opcode == D_GRANT_DATA);
  endfunction

  function automatic logic is_grant(input logic [2:0] opcode);
    return (opcode == D_GRANT) || (opcode == D_GRANT_DATA);
  endfunction

  // Unclamped beat count; the caller limits it to the line size.
  function automatic logic [4:0] beats_of(input logic [2:0] opcode, input logic [2:0] size);
    logic [4:0] beats;
    beats = 5'd1;
    if (is_data(opcode) && (size > TL_BEAT_LOG2)) begin
      beats = 5'd1 << (size - TL_BEAT_LOG2);
    end
    return beats;
  endfunction

endpackage

// File: rtl/tl_line_buffer.sv
// Line assembly storage: MAX_BEATS x DATA_W registers, whole-line clear plus one beat write per cycle.
// A write in the clear cycle wins for its slot; contents are not reset.
module tl_line_buffer #(
  parameter int MAX_BEATS = 8,
  parameter int DATA_W    = 64
) (
  input  logic                          clock,
  input  logic                          clr,
  input  logic                          wr_en,
  input  logic [$clog2(MAX_BEATS)-1:0]  wr_idx,
  input  logic [DATA_W-1:0]             wr_dat,
  output logic [DATA_W*MAX_BEATS-1:0]   rd_line
);

  localparam int IDX_W = $clog2(MAX_BEATS);

  logic [DATA_W-1:0] mem_q [MAX_BEATS];
  logic [DATA_W-1:0] mem_d [MAX_BEATS];

  always_comb begin
    for (int i = 0; i < MAX_BEATS; i++) begin
      mem_d[i] = clr ? '0 : mem_q[i];
      if (wr_en && (wr_idx == IDX_W'(i))) begin
        mem_d[i] = wr_dat;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < MAX_BEATS; i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

  always_comb begin
    rd_line = '0;
    for (int i = 0; i < MAX_BEATS; i++) begin
      rd_line[i*DATA_W +: DATA_W] = mem_q[i];
    end
  end

endmodule

// File: rtl/tl_d_refill_collector.sv
// Collects one TileLink D message into a full-line response and issues GrantAck on E for Grant/GrantData.
// Response and E valid rise the cycle after the last beat; D is held off until both are taken.
module tl_d_refill_collector
  import tl_pkg::*;
#(
  parameter int BEAT_BYTES = TL_BEAT_BYTES,
  parameter int LINE_BYTES = TL_LINE_BYTES,
  parameter int SOURCE_W   = TL_SOURCE_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    d_valid,
  output logic                    d_ready,
  input  logic [2:0]              d_opcode,
  input  logic [1:0]              d_param,
  input  logic [2:0]              d_size,
  input  logic [SOURCE_W-1:0]     d_source,
  input  logic                    d_sink,
  input  logic                    d_denied,
  input  logic [8*BEAT_BYTES-1:0] d_data,
  input  logic                    d_corrupt,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [2:0]              resp_opcode,
  output logic [1:0]              resp_param,
  output logic [SOURCE_W-1:0]     resp_source,
  output logic [2:0]              resp_size,
  output logic                    resp_denied,
  output logic                    resp_corrupt,
  output logic [8*LINE_BYTES-1:0] resp_data,
  output logic                    e_valid,
  input  logic                    e_ready,
  output logic                    e_sink,
  output logic                    err_size
);

  localparam int DATA_W    = 8 * BEAT_BYTES;
  localparam int MAX_BEATS = LINE_BYTES / BEAT_BYTES;
  localparam int IDX_W     = $clog2(MAX_BEATS);
  localparam int BCNT_W    = IDX_W + 1;
  localparam logic [3:0] LINE_LOG2 = 4'($clog2(LINE_BYTES));

  d_beat_t d_beat;

  fill_state_e           state_q, state_d;
  logic [BCNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [BCNT_W-1:0]     beats_q, beats_d;
  logic [2:0]            opcode_q, opcode_d;
  logic [1:0]            param_q, param_d;
  logic [2:0]            size_q, size_d;
  logic [SOURCE_W-1:0]   source_q, source_d;
  logic                  sink_q, sink_d;
  logic                  denied_q, denied_d;
  logic                  corrupt_q, corrupt_d;
  logic                  resp_pend_q, resp_pend_d;
  logic                  e_pend_q, e_pend_d;
  logic                  err_size_q, err_size_d;

  logic                  d_hs;
  logic                  resp_hs;
  logic                  e_hs;
  logic                  oversize;
  logic [4:0]            raw_beats;
  logic [BCNT_W-1:0]     new_beats;
  logic                  buf_clr;
  logic                  buf_wr_en;
  logic [IDX_W-1:0]      buf_wr_idx;

  assign d_beat = '{opcode:  d_opcode,
                    param:   d_param,
                    size:    d_size,
                    source:  d_source,
                    sink:    d_sink,
                    denied:  d_denied,
                    data:    d_data,
                    corrupt: d_corrupt};

  assign d_ready = (state_q != ST_DONE);
  assign d_hs    = d_valid && d_ready;
  assign resp_hs = resp_pend_q && resp_ready;
  assign e_hs    = e_pend_q && e_ready;

  // Oversize data messages fill the whole line and stop there.
  assign oversize  = ({1'b0, d_beat.size} > LINE_LOG2);
  assign raw_beats = beats_of(d_beat.opcode, d_beat.size);
  assign new_beats = (raw_beats > 5'(MAX_BEATS)) ? BCNT_W'(MAX_BEATS) : BCNT_W'(raw_beats);

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    beats_d     = beats_q;
    opcode_d    = opcode_q;
    param_d     = param_q;
    size_d      = size_q;
    source_d    = source_q;
    sink_d      = sink_q;
    denied_d    = denied_q;
    corrupt_d   = corrupt_q;
    resp_pend_d = resp_pend_q;
    e_pend_d    = e_pend_q;
    err_size_d  = err_size_q;
    buf_clr     = 1'b0;
    buf_wr_en   = 1'b0;
    buf_wr_idx  = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (d_hs) begin
          opcode_d   = d_beat.opcode;
          param_d    = d_beat.param;
          size_d     = d_beat.size;
          source_d   = d_beat.source;
          sink_d     = d_beat.sink;
          denied_d   = d_beat.denied;
          corrupt_d  = d_beat.corrupt;
          beats_d    = new_beats;
          beat_cnt_d = BCNT_W'(1);
          err_size_d = err_size_q || oversize;
          buf_clr    = 1'b1;
          // Non-data messages leave the line at zero.
          buf_wr_en  = is_data(d_beat.opcode);
          if (new_beats == BCNT_W'(1)) begin
            state_d     = ST_DONE;
            resp_pend_d = 1'b1;
            e_pend_d    = is_grant(d_beat.opcode);
          end else begin
            state_d = ST_FILL;
          end
        end
      end

      ST_FILL: begin
        if (d_hs) begin
          buf_wr_en  = 1'b1;
          buf_wr_idx = beat_cnt_q[IDX_W-1:0];
          denied_d   = denied_q || d_beat.denied;
          corrupt_d  = corrupt_q || d_beat.corrupt;
          beat_cnt_d = beat_cnt_q + BCNT_W'(1);
          if (beat_cnt_q == (beats_q - BCNT_W'(1))) begin
            state_d     = ST_DONE;
            resp_pend_d = 1'b1;
            e_pend_d    = is_grant(opcode_q);
          end
        end
      end

      ST_DONE: begin
        if (resp_hs) begin
          resp_pend_d = 1'b0;
        end
        if (e_hs) begin
          e_pend_d = 1'b0;
        end
        if (!resp_pend_d && !e_pend_d) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      resp_pend_q <= 1'b0;
      e_pend_q    <= 1'b0;
      err_size_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      resp_pend_q <= resp_pend_d;
      e_pend_q    <= e_pend_d;
      err_size_q  <= err_size_d;
    end
  end

  // Header capture only matters while a valid is raised, so it carries no reset.
  always_ff @(posedge clock) begin
    beats_q   <= beats_d;
    opcode_q  <= opcode_d;
    param_q   <= param_d;
    size_q    <= size_d;
    source_q  <= source_d;
    sink_q    <= sink_d;
    denied_q  <= denied_d;
    corrupt_q <= corrupt_d;
  end

  tl_line_buffer #(
    .MAX_BEATS (MAX_BEATS),
    .DATA_W    (DATA_W)
  ) u_line_buffer (
    .clock   (clock),
    .clr     (buf_clr),
    .wr_en   (buf_wr_en),
    .wr_idx  (buf_wr_idx),
    .wr_dat  (d_beat.data),
    .rd_line (resp_data)
  );

  assign resp_valid   = resp_pend_q;
  assign resp_opcode  = opcode_q;
  assign resp_param   = param_q;
  assign resp_source  = source_q;
  assign resp_size    = size_q;
  assign resp_denied  = denied_q;
  assign resp_corrupt = corrupt_q;
  assign e_valid      = e_pend_q;
  assign e_sink       = sink_q;
  assign err_size     = err_size_q;

endmodule

// File: tb/tb_tl_d_refill_collector.sv
// Directed bench for tl_d_refill_collector: table of single-beat messages plus multi-beat sequences.
module tb_tl_d_refill_collector;
  import tl_pkg::*;

  logic         clock = 1'b0;
  logic         reset;
  logic         d_valid;
  logic         d_ready;
  logic [2:0]   d_opcode;
  logic [1:0]   d_param;
  logic [2:0]   d_size;
  logic [5:0]   d_source;
  logic         d_sink;
  logic         d_denied;
  logic [63:0]  d_data;
  logic         d_corrupt;
  logic         resp_valid;
  logic         resp_ready;
  logic [2:0]   resp_opcode;
  logic [1:0]   resp_param;
  logic [5:0]   resp_source;
  logic [2:0]   resp_size;
  logic         resp_denied;
  logic         resp_corrupt;
  logic [511:0] resp_data;
  logic         e_valid;
  logic         e_ready;
  logic         e_sink;
  logic         err_size;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  tl_d_refill_collector dut (
    .clock        (clock),
    .reset        (reset),
    .d_valid      (d_valid),
    .d_ready      (d_ready),
    .d_opcode     (d_opcode),
    .d_param      (d_param),
    .d_size       (d_size),
    .d_source     (d_source),
    .d_sink       (d_sink),
    .d_denied     (d_denied),
    .d_data       (d_data),
    .d_corrupt    (d_corrupt),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_opcode  (resp_opcode),
    .resp_param   (resp_param),
    .resp_source  (resp_source),
    .resp_size    (resp_size),
    .resp_denied  (resp_denied),
    .resp_corrupt (resp_corrupt),
    .resp_data    (resp_data),
    .e_valid      (e_valid),
    .e_ready      (e_ready),
    .e_sink       (e_sink),
    .err_size     (err_size)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [1:0]  prm;
    logic [2:0]  sz;
    logic [5:0]  src;
    logic        snk;
    logic        den;
    logic        cor;
    logic [63:0] dat;
    logic        exp_e;
    logic [63:0] exp_dat;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the handshake.
  task automatic send_beat(input logic [2:0] op, input logic [1:0] prm, input logic [2:0] sz,
                           input logic [5:0] src, input logic snk, input logic den,
                           input logic [63:0] dat, input logic cor);
    int n;
    n = 0;
    d_opcode  = op;
    d_param   = prm;
    d_size    = sz;
    d_source  = src;
    d_sink    = snk;
    d_denied  = den;
    d_data    = dat;
    d_corrupt = cor;
    d_valid   = 1'b1;
    while (!d_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!d_ready) begin
      chk("d_ready_timeout", d_ready, 1);
      d_valid = 1'b0;
      return;
    end
    @(posedge clock);
    @(negedge clock);
    d_valid = 1'b0;
  endtask

  task automatic take_both();
    resp_ready = 1'b1;
    e_ready    = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resp_ready = 1'b0;
    e_ready    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [511:0] exp_line;
    logic [7:0]   b;
    logic [63:0]  beat_a;
    logic [63:0]  beat_b;

    vecs[0] = '{"ack",         D_ACCESS_ACK,      2'd0, 3'd3, 6'd5,  1'b0, 1'b0, 1'b0, 64'hDEAD_BEEF_0000_1111, 1'b0, 64'h0};
    vecs[1] = '{"release_ack", D_RELEASE_ACK,     2'd0, 3'd6, 6'd9,  1'b0, 1'b1, 1'b0, 64'h1234,                1'b0, 64'h0};
    vecs[2] = '{"grant",       D_GRANT,           2'd1, 3'd6, 6'd3,  1'b1, 1'b0, 1'b0, 64'h5555,                1'b1, 64'h0};
    vecs[3] = '{"aad_1beat",   D_ACCESS_ACK_DATA, 2'd0, 3'd3, 6'h3F, 1'b0, 1'b0, 1'b1, 64'hCAFE_F00D_0123_4567, 1'b0, 64'hCAFE_F00D_0123_4567};
    vecs[4] = '{"aad_1byte",   D_ACCESS_ACK_DATA, 2'd0, 3'd0, 6'd0,  1'b0, 1'b0, 1'b0, 64'hA5,                  1'b0, 64'hA5};
    vecs[5] = '{"gd_1beat",    D_GRANT_DATA,      2'd2, 3'd3, 6'd17, 1'b0, 1'b0, 1'b0, 64'h0BAD_F00D,           1'b1, 64'h0BAD_F00D};

    reset      = 1'b1;
    d_valid    = 1'b0;
    d_opcode   = '0;
    d_param    = '0;
    d_size     = '0;
    d_source   = '0;
    d_sink     = 1'b0;
    d_denied   = 1'b0;
    d_data     = '0;
    d_corrupt  = 1'b0;
    resp_ready = 1'b0;
    e_ready    = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    chk("rst_d_ready", d_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_e_valid", e_valid, 0);
    chk("rst_err_size", err_size, 0);

    // Single-beat messages: response the cycle after the beat, then back to idle.
    for (int i = 0; i < 6; i++) begin
      send_beat(vecs[i].op, vecs[i].prm, vecs[i].sz, vecs[i].src, vecs[i].snk,
                vecs[i].den, vecs[i].dat, vecs[i].cor);
      chk({vecs[i].name, "_resp_valid"}, resp_valid, 1);
      chk({vecs[i].name, "_d_ready_busy"}, d_ready, 0);
      chk({vecs[i].name, "_opcode"}, resp_opcode, vecs[i].op);
      chk({vecs[i].name, "_param"}, resp_param, vecs[i].prm);
      chk({vecs[i].name, "_source"}, resp_source, vecs[i].src);
      chk({vecs[i].name, "_size"}, resp_size, vecs[i].sz);
      chk({vecs[i].name, "_denied"}, resp_denied, vecs[i].den);
      chk({vecs[i].name, "_corrupt"}, resp_corrupt, vecs[i].cor);
      chk({vecs[i].name, "_data"}, resp_data, {448'h0, vecs[i].exp_dat});
      chk({vecs[i].name, "_e_valid"}, e_valid, vecs[i].exp_e);
      if (vecs[i].exp_e) chk({vecs[i].name, "_e_sink"}, e_sink, vecs[i].snk);
      take_both();
      chk({vecs[i].name, "_d_ready_after"}, d_ready, 1);
      chk({vecs[i].name, "_resp_valid_after"}, resp_valid, 0);
      chk({vecs[i].name, "_e_valid_after"}, e_valid, 0);
    end

    // AccessAckData, 8 beats of 0x11..0x88 replicated, continuous valid.
    exp_line = '0;
    for (int k = 0; k < 8; k++) begin
      b = 8'((k + 1) * 17);
      exp_line[64*k +: 64] = {8{b}};
      send_beat(D_ACCESS_ACK_DATA, 2'd0, 3'd6, 6'd7, 1'b0, 1'b0, {8{b}}, 1'b0);
      if (k == 6) chk("aad8_resp_early", resp_valid, 0);
    end
    chk("aad8_resp_valid", resp_valid, 1);
    chk("aad8_e_valid", e_valid, 0);
    chk("aad8_beat0", resp_data[63:0], 64'h1111_1111_1111_1111);
    chk("aad8_beat7", resp_data[511:448], 64'h8888_8888_8888_8888);
    chk("aad8_line", resp_data, exp_line);
    chk("aad8_size", resp_size, 3'd6);
    repeat (2) @(negedge clock);
    chk("aad8_d_ready_held", d_ready, 0);
    chk("aad8_resp_held", resp_valid, 1);
    chk("aad8_line_stable", resp_data, exp_line);
    take_both();
    chk("aad8_d_ready_after", d_ready, 1);

    // GrantData with corrupt on beat 3 and garbage header fields on later beats.
    exp_line = '0;
    for (int k = 0; k < 8; k++) begin
      b = 8'(k + 8'h20);
      exp_line[64*k +: 64] = {8{b}};
      send_beat(D_GRANT_DATA, (k == 0) ? 2'd2 : 2'd1, (k == 0) ? 3'd6 : 3'd2,
                (k == 0) ? 6'd12 : 6'd63, (k == 0), 1'b0, {8{b}}, (k == 3));
    end
    chk("gd_resp_valid", resp_valid, 1);
    chk("gd_opcode", resp_opcode, D_GRANT_DATA);
    chk("gd_param", resp_param, 2'd2);
    chk("gd_source", resp_source, 6'd12);
    chk("gd_size", resp_size, 3'd6);
    chk("gd_corrupt", resp_corrupt, 1);
    chk("gd_denied", resp_denied, 0);
    chk("gd_line", resp_data, exp_line);
    chk("gd_e_valid", e_valid, 1);
    chk("gd_e_sink", e_sink, 1);
    resp_ready = 1'b1;
    e_ready    = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clock);
      @(negedge clock);
      chk("gd_d_ready_e_wait", d_ready, 0);
      chk("gd_e_valid_held", e_valid, 1);
    end
    chk("gd_resp_taken", resp_valid, 0);
    chk("gd_e_sink_stable", e_sink, 1);
    e_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    e_ready    = 1'b0;
    resp_ready = 1'b0;
    chk("gd_d_ready_after_e", d_ready, 1);
    chk("gd_e_valid_after", e_valid, 0);

    // Reset after beat 4 of 8 discards the partial line.
    for (int k = 0; k < 4; k++) begin
      send_beat(D_ACCESS_ACK_DATA, 2'd0, 3'd6, 6'd4, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    end
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_e_valid", e_valid, 0);
    chk("midrst_d_ready", d_ready, 1);
    repeat (3) @(negedge clock);
    chk("midrst_resp_quiet", resp_valid, 0);
    beat_a = 64'h0102_0304_0506_0708;
    beat_b = 64'hF0E0_D0C0_B0A0_9080;
    send_beat(D_ACCESS_ACK_DATA, 2'd0, 3'd4, 6'd2, 1'b0, 1'b0, beat_a, 1'b0);
    chk("sz4_resp_early", resp_valid, 0);
    send_beat(D_ACCESS_ACK_DATA, 2'd0, 3'd4, 6'd2, 1'b0, 1'b0, beat_b, 1'b0);
    chk("sz4_resp_valid", resp_valid, 1);
    chk("sz4_line", resp_data, {384'h0, beat_b, beat_a});
    chk("sz4_size", resp_size, 3'd4);
    chk("sz4_source", resp_source, 6'd2);
    take_both();
    chk("sz4_err_size", err_size, 0);

    // Oversize (size 7) AccessAckData: flagged, 8 beats consumed, response produced.
    exp_line = '0;
    for (int k = 0; k < 8; k++) begin
      b = 8'(k + 1);
      exp_line[64*k +: 64] = {8{b}};
      send_beat(D_ACCESS_ACK_DATA, 2'd0, 3'd7, 6'd1, 1'b0, (k == 5), {8{b}}, 1'b0);
      if (k == 0) chk("sz7_err_set", err_size, 1);
      if (k == 6) chk("sz7_resp_early", resp_valid, 0);
    end
    chk("sz7_resp_valid", resp_valid, 1);
    chk("sz7_size", resp_size, 3'd7);
    chk("sz7_denied", resp_denied, 1);
    chk("sz7_line", resp_data, exp_line);
    take_both();
    chk("sz7_d_ready_after", d_ready, 1);
    send_beat(D_ACCESS_ACK, 2'd0, 3'd3, 6'd8, 1'b0, 1'b0, 64'h0, 1'b0);
    chk("sz7_next_resp", resp_valid, 1);
    chk("sz7_err_sticky", err_size, 1);
    take_both();
    chk("sz7_err_sticky_idle", err_size, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tl_d_refill_collector.md
Name: tl_d_refill_collector

Overview:
- Consumes the TileLink D channel at the output of the 2-entry D-channel buffer queue (64-bit beats).
- Counts beats per message and assembles multi-beat AccessAckData/GrantData payloads into one full-line response for the cache/LSU refill path.
- Generates the E-channel GrantAck for Grant/GrantData.
- Single-message-in-flight design; backpressures D while a completed response or GrantAck is outstanding.

Parameters:
- BEAT_BYTES, 8, bytes per D beat; data width = 8*BEAT_BYTES.
- LINE_BYTES, 64, maximum message size; MAX_BEATS = LINE_BYTES/BEAT_BYTES.
- SOURCE_W, 6, width of the D source field.

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high reset
- d_valid  in  1  D beat valid
- d_ready  out  1  D beat accepted when d_valid & d_ready
- d_opcode  in  3  TL D opcode
- d_param  in  2  TL D param
- d_size  in  3  log2 message bytes
- d_source  in  SOURCE_W  transaction id
- d_sink  in  1  manager sink id
- d_denied  in  1  denied flag
- d_data  in  64  beat data
- d_corrupt  in  1  corrupt flag
- resp_valid  out  1  assembled response valid
- resp_ready  in  1  consumer accepts response
- resp_opcode  out  3  opcode of the message
- resp_param  out  2  param of the message
- resp_source  out  SOURCE_W  source of the message
- resp_size  out  3  size of the message
- resp_denied  out  1  OR of denied over all beats
- resp_corrupt  out  1  OR of corrupt over all beats
- resp_data  out  8*LINE_BYTES  line data; beat k at bits [64k+63:64k]
- e_valid  out  1  GrantAck valid
- e_ready  in  1  E channel accepts
- e_sink  out  1  sink captured from the Grant/GrantData
- err_size  out  1  sticky; set when d_size > log2(LINE_BYTES) is accepted

Behaviour:
- Beat count:
  - Data opcodes (1 AccessAckData, 5 GrantData) with d_size > 3: beats = 1 << (d_size-3).
  - All other cases: 1 beat.
  - Oversize messages set err_size and are treated as MAX_BEATS.
- FSM states: IDLE, FILL, DONE.
  - IDLE:
    - d_ready=1.
    - On the first-beat handshake: capture opcode, param, size, source, sink; clear the line buffer to zero; write beat 0; init denied/corrupt accumulators from the beat; set beat_cnt=1.
    - If beats==1, go to DONE; else go to FILL.
  - FILL:
    - d_ready=1.
    - Each handshake writes beat beat_cnt, ORs in denied/corrupt, and increments beat_cnt.
    - Header fields of later beats are ignored.
    - On the handshake where beat_cnt == beats-1, go to DONE.
  - DONE:
    - d_ready=0.
    - resp_valid=1 until resp_ready.
    - e_valid=1 until e_ready, only if the captured opcode is 4 or 5; otherwise the E-pending flag is never set.
    - The two handshakes are independent and may complete in the same cycle or either order.
    - Go to IDLE the cycle after both pending flags are clear.
- Latency: resp_valid and e_valid rise the cycle after the last beat handshake. Minimum per-message occupancy is beats+1 cycles.
- D opcode 6 (ReleaseAck) and other non-data opcodes: single beat, resp_data all zero, response still produced.
- beat_cnt width: log2(MAX_BEATS)+1 bits; no wrap within a message.
- Reset values:
  - state=IDLE, beat_cnt=0, pending flags=0, err_size=0.
  - resp_valid=0, e_valid=0; d_ready=1 from the first cycle after reset.
  - resp_* and e_sink are don't-care while the corresponding valid is low; the data buffer is not reset.
- Reset mid-message discards the partial line. No response or E is emitted.
- resp_* and e_sink are stable while their valid is held.

Decomposition:
- Shared package tl_pkg holds:
  - D opcode constants (AccessAck=0, AccessAckData=1, Grant=4, GrantData=5, ReleaseAck=6).
  - BEAT_BYTES and LINE_BYTES defaults.
  - A d_beat_t struct typedef.
  - A function beats_of(opcode, size).
- One sub-module, tl_line_buffer: a MAX_BEATS x 64 register array with clear, beat write-enable/index, and a flat read-out.

Test Plan:
- Single AccessAck (opcode 0, size 3, source 5) -> the next cycle resp_valid=1, resp_source=5, resp_data=0, e_valid stays 0; IDLE after resp_ready.
- AccessAckData size 6, 8 beats with data 0x11..0x88 replicated per byte, continuous valid -> resp_valid rises 1 cycle after beat 8; resp_data[63:0]=0x1111..., [511:448]=0x8888...; d_ready=0 until resp_ready.
- GrantData size 6, sink 1, beat 3 corrupt=1 -> resp_corrupt=1, e_valid=1 with e_sink=1; hold e_ready=0 for 5 cycles while resp_ready=1 -> d_ready stays 0 until the cycle after e handshake.
- Grant (opcode 4, no data), resp_ready and e_ready both 1 in the DONE cycle -> both handshakes in one cycle; d_ready=1 on the following cycle.
- Reset asserted after beat 4 of an 8-beat message -> no resp_valid/e_valid; a new size-4 AccessAckData (2 beats) completes correctly with zero upper beats.
- Size 7 AccessAckData -> err_size=1 (sticky), 8 beats consumed, response produced.
